// File: rtl/mem_bus_arb3_pkg.sv
// Shared codes for the three-way memory bus arbiter: bus opm/OK encodings,
// arbiter FSM state encodings and the round-robin increment helper.
package mem_bus_arb3_pkg;

    // Bus operation codes; READY means the requester is idle.
    localparam logic [4:0] UMEM_OPM_READY = 5'h00;
    localparam logic [4:0] UMEM_OPM_LOAD  = 5'h08;
    localparam logic [4:0] UMEM_OPM_STORE = 5'h10;

    // Bus response codes.
    localparam logic [1:0] UMEM_OK_READY = 2'b00;
    localparam logic [1:0] UMEM_OK_OK    = 2'b01;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
    localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1,
        ARB_DRAIN  = 2'd2
    } arb_state_t;

    localparam logic [1:0] ARB_OWNER_NONE = 2'd3;

    // Next index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_inc3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arb_rr3.sv
// Combinational 3-way round-robin picker: first set bit of req scanning
// ptr, ptr+1, ptr+2 (mod 3). A ptr of 3 is treated as 0.
module mem_arb_rr3
    import mem_bus_arb3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    // Scan the three candidates in rotation order, lowest offset wins.
    always_comb begin
        p0    = (ptr == 2'd3) ? 2'd0 : ptr;
        p1    = rr_inc3(p0);
        p2    = rr_inc3(p1);
        idx   = 2'd0;
        valid = 1'b1;
        if (req[p0])      idx = p0;
        else if (req[p1]) idx = p1;
        else if (req[p2]) idx = p2;
        else              valid = 1'b0;
    end

endmodule

// File: rtl/mem_bus_arb3.sv
// Three-requester arbiter sharing one 128-bit memory bus port.
//
// Handshake: a requester asks for the bus by driving a non-READY opm and
// holds addr/opm/data stable until it has seen OK on its rqOK; it then drops
// opm to READY. The owner's rqOK mirrors memOK, waiting requesters see HOLD,
// idle ones see READY. A grant is held until the bus returns memOK==READY
// after the owner has dropped opm, so the bus never sees a transaction torn
// between two masters.
module mem_bus_arb3
    import mem_bus_arb3_pkg::*;
#(
    parameter int WDOG_BITS = 12,
    parameter int PRIO_RST  = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  rqAddr0,
    input  logic [31:0]  rqAddr1,
    input  logic [31:0]  rqAddr2,
    input  logic [4:0]   rqOpm0,
    input  logic [4:0]   rqOpm1,
    input  logic [4:0]   rqOpm2,
    input  logic [127:0] rqDataOut0,
    input  logic [127:0] rqDataOut1,
    input  logic [127:0] rqDataOut2,
    output logic [127:0] rqDataIn,
    output logic [1:0]   rqOK0,
    output logic [1:0]   rqOK1,
    output logic [1:0]   rqOK2,
    output logic [31:0]  memAddr,
    output logic [4:0]   memOpm,
    output logic [127:0] memDataOut,
    input  logic [127:0] memDataIn,
    input  logic [1:0]   memOK,
    output logic [1:0]   arbOwner,
    output logic         arbWdogFault
);

    // A zero-width counter is not legal; keep one bit and gate it off.
    localparam int WB = (WDOG_BITS > 0) ? WDOG_BITS : 1;

    arb_state_t    state, state_n;
    logic [1:0]    owner, owner_n;
    logic [1:0]    rr_ptr, rr_ptr_n;
    logic [WB-1:0] wdog, wdog_n;

    logic [2:0]    req;
    logic [1:0]    pick_idx;
    logic          pick_valid;
    logic [4:0]    own_opm;
    logic          wd_hit;
    logic [1:0]    fwd_idx;
    logic          fwd_valid;
    logic          bus_fwd;
    logic [1:0]    ok_val;

    assign req = {rqOpm2 != UMEM_OPM_READY,
                  rqOpm1 != UMEM_OPM_READY,
                  rqOpm0 != UMEM_OPM_READY};

    mem_arb_rr3 u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A response of OK in the expiry cycle proves the transaction is alive,
    // so it suppresses the fault.
    assign wd_hit = (WDOG_BITS > 0) && (state != ARB_IDLE) && (&wdog)
                    && (memOK != UMEM_OK_OK);

    assign arbOwner = owner;
    assign rqDataIn = memDataIn;

    // Current owner's opm, used to detect drop and re-assert.
    always_comb begin
        case (owner)
            2'd0:    own_opm = rqOpm0;
            2'd1:    own_opm = rqOpm1;
            2'd2:    own_opm = rqOpm2;
            default: own_opm = UMEM_OPM_READY;
        endcase
    end

    // State register: FSM state, owner, rotation pointer, watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ARB_IDLE;
            owner  <= ARB_OWNER_NONE;
            rr_ptr <= 2'(PRIO_RST);
            wdog   <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
            wdog   <= wdog_n;
        end
    end

    // Next-state logic: grant, drop/drain, release and watchdog expiry.
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        wdog_n   = wdog;
        if (state != ARB_IDLE)
            wdog_n = (memOK == UMEM_OK_OK) ? '0 : wdog + WB'(1);
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_n = ARB_ACTIVE;
                    owner_n = pick_idx;
                    wdog_n  = '0;
                end
            end
            ARB_ACTIVE: begin
                if (wd_hit) begin
                    state_n = ARB_DRAIN;
                    wdog_n  = '0;
                end else if (own_opm == UMEM_OPM_READY) begin
                    if (memOK == UMEM_OK_READY) begin
                        state_n  = ARB_IDLE;
                        owner_n  = ARB_OWNER_NONE;
                        rr_ptr_n = rr_inc3(owner);
                    end else begin
                        state_n = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                if (wd_hit) begin
                    wdog_n = '0;
                end else if (own_opm != UMEM_OPM_READY) begin
                    // Owner keeps the bus: no re-arbitration.
                    state_n = ARB_ACTIVE;
                end else if (memOK == UMEM_OK_READY) begin
                    state_n  = ARB_IDLE;
                    owner_n  = ARB_OWNER_NONE;
                    rr_ptr_n = rr_inc3(owner);
                end
            end
            default: begin
                state_n = ARB_IDLE;
                owner_n = ARB_OWNER_NONE;
            end
        endcase
    end

    // Output logic: forward the winner/owner to the bus and route responses.
    always_comb begin
        memOpm       = UMEM_OPM_READY;
        memAddr      = '0;
        memDataOut   = '0;
        arbWdogFault = 1'b0;
        rqOK0        = req[0] ? UMEM_OK_HOLD : UMEM_OK_READY;
        rqOK1        = req[1] ? UMEM_OK_HOLD : UMEM_OK_READY;
        rqOK2        = req[2] ? UMEM_OK_HOLD : UMEM_OK_READY;
        fwd_idx      = ARB_OWNER_NONE;
        fwd_valid    = 1'b0;
        bus_fwd      = 1'b0;
        ok_val       = wd_hit ? UMEM_OK_FAULT : memOK;
        if (reset) begin
            rqOK0 = UMEM_OK_READY;
            rqOK1 = UMEM_OK_READY;
            rqOK2 = UMEM_OK_READY;
        end else begin
            case (state)
                ARB_IDLE: begin
                    fwd_idx   = pick_idx;
                    fwd_valid = pick_valid;
                    bus_fwd   = pick_valid;
                end
                ARB_ACTIVE: begin
                    fwd_idx   = owner;
                    fwd_valid = 1'b1;
                    bus_fwd   = !wd_hit;
                end
                ARB_DRAIN: begin
                    fwd_idx   = owner;
                    fwd_valid = 1'b1;
                end
                default: ;
            endcase
            if (bus_fwd) begin
                case (fwd_idx)
                    2'd0: begin memAddr = rqAddr0; memOpm = rqOpm0; memDataOut = rqDataOut0; end
                    2'd1: begin memAddr = rqAddr1; memOpm = rqOpm1; memDataOut = rqDataOut1; end
                    2'd2: begin memAddr = rqAddr2; memOpm = rqOpm2; memDataOut = rqDataOut2; end
                    default: ;
                endcase
            end
            if (fwd_valid) begin
                case (fwd_idx)
                    2'd0:    rqOK0 = ok_val;
                    2'd1:    rqOK1 = ok_val;
                    2'd2:    rqOK2 = ok_val;
                    default: ;
                endcase
            end
            arbWdogFault = wd_hit;
        end
    end

endmodule

// File: doc/mem_bus_arb3.md
Name: mem_bus_arb3

Overview:
- Three-requester arbiter sharing one 128-bit memory bus port between the L1 I$, the L1 D$ and a third master (page-walker/DMA).
- Sits between the L1 wrappers and the L2/bus bridge.
- Uses the opm/OK handshake (UMEM_OPM_*, UMEM_OK_*).
- Grants by round-robin and holds a grant until the transaction fully drains; a watchdog faults hung transactions.

Parameters:
- WDOG_BITS, 12, width of the per-grant watchdog counter; 0 disables the watchdog.
- PRIO_RST, 0, index of the highest-priority requester after reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rqAddr0/1/2  in  32 each  requester n address.
- rqOpm0/1/2  in  5 each  requester n operation; UMEM_OPM_READY means idle.
- rqDataOut0/1/2  in  128 each  requester n store data.
- rqDataIn  out  128  load data, broadcast to all requesters (= memDataIn).
- rqOK0/1/2  out  2 each  per-requester OK response.
- memAddr  out  32  bus address.
- memOpm  out  5  bus operation.
- memDataOut  out  128  bus store data.
- memDataIn  in  128  bus load data.
- memOK  in  2  bus response.
- arbOwner  out  2  current owner (3 = none), for debug and perf counters.
- arbWdogFault  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, ACTIVE, DRAIN. Registers: state, owner[1:0], rrPtr[1:0], wdog[WDOG_BITS-1:0].
- Reset values:
  - state=IDLE, owner=3, rrPtr=PRIO_RST, wdog=0.
  - Combinationally under reset: memOpm=READY, every rqOK=READY, arbWdogFault=0.
- Default drive (no owner):
  - memOpm=READY; memAddr and memDataOut don't-care (drive 0).
  - rqOKn=HOLD if rqOpmn!=READY, else READY.
- IDLE:
  - The winner is the first requester with a nonzero opm, scanning rrPtr, rrPtr+1, rrPtr+2 mod 3.
  - The winner is forwarded combinationally in the same cycle (zero added latency). Its rqOK=memOK; the others get the default drive.
  - Next state is ACTIVE with owner=winner. With no requests, stay in IDLE.
- ACTIVE:
  - Forward the owner's addr/opm/data to the bus; owner's rqOK=memOK; non-owners get the default drive.
  - If the owner's opm becomes READY: go to IDLE when memOK==READY that cycle, otherwise go to DRAIN.
- DRAIN:
  - memOpm=READY; the owner still sees memOK.
  - Go to IDLE when memOK==READY.
  - If the owner re-asserts opm while in DRAIN, return to ACTIVE. No re-arbitration in this case.
- Release:
  - On any transition to IDLE: rrPtr=(owner+1) mod 3, owner=3.
  - The release cycle is not a grant cycle. A pending request is granted in the following IDLE cycle.
- Watchdog (WDOG_BITS>0):
  - wdog clears on grant and on every cycle with memOK==OK. It increments in ACTIVE/DRAIN otherwise.
  - On reaching all-ones, in one cycle: owner's rqOK=FAULT, arbWdogFault=1, memOpm=READY, go to DRAIN.
  - From there, DRAIN completes on memOK==READY.
- Simultaneous events: three requests in the same cycle follow strict rrPtr order. A request that appears mid-transaction waits with HOLD.
- Reset mid-transaction: the state returns to IDLE at once. The bus sees opm=READY in the reset cycle, and nothing is latched.

Decomposition:
- Shared package:
  - UMEM_OPM_* and UMEM_OK_* codes (existing constants).
  - State encodings ARB_IDLE=0, ARB_ACTIVE=1, ARB_DRAIN=2.
  - ARB_OWNER_NONE=3.
- One natural sub-module: mem_arb_rr3. It is a combinational 3-way round-robin picker taking req[2:0] and ptr[1:0] and returning grant index and valid.
- Everything else stays flat in mem_bus_arb3.

Test Plan:
- Single requester:
  - Stimulus: rqOpm1=LOAD, addr 0x00001000; memOK HOLD for 3 cycles, then OK with memDataIn=0x1234…; opm dropped; memOK=READY.
  - Required: memOpm=LOAD in cycle 0; rqOK1 follows memOK; after release, rrPtr=2 and arbOwner=3.
- Three simultaneous requests from reset (rrPtr=0):
  - Grants go in order 0, 1, 2.
  - Each waiting requester sees HOLD until granted.
  - Exactly one idle cycle between grants.
- Drain and mid-transaction request:
  - Stimulus: owner 0 drops opm while memOK=HOLD for 2 more cycles; requester 1 asserts during this.
  - Required: memOpm=READY during DRAIN; rqOK1=HOLD; requester 1 is granted only after memOK=READY.
- Watchdog (WDOG_BITS=4):
  - Stimulus: memOK held at HOLD indefinitely.
  - Required: after 15 cycles, the owner sees FAULT for one cycle, arbWdogFault pulses once, and the state goes to DRAIN.
  - When memOK then returns READY: IDLE.
- Reset mid-ACTIVE:
  - Stimulus: assert reset for 1 cycle during a store.
  - Required: memOpm=READY that cycle; arbOwner=3 and rrPtr=PRIO_RST afterwards; the next request is granted normally.
- Re-assert in DRAIN:
  - Stimulus: owner 2 re-asserts STORE while in DRAIN.
  - Required: return to ACTIVE with owner 2, no re-arbitration, and requester 0 keeps HOLD.
